// File: rtl/pid_dac_spi_if.sv
// Sample handshake from the PID limiter and the 3-wire SPI + LDAC pins to the DAC.
interface pid_dac_spi_if #(
    parameter int In_width = 32
);
    logic [In_width-1:0] data;
    logic                valid;
    logic                ready;
    logic                sclk;
    logic                sdi;
    logic                csn;
    logic                ldacn;

    modport master (output data, valid, input ready, sclk, sdi, csn, ldacn);
    modport slave  (input data, valid, output ready, sclk, sdi, csn, ldacn);
endinterface

// File: rtl/pid_dac_spi.sv
// PID output stage: saturate sample to DAC code, shift MSB-first over SPI, pulse LDAC.
// Optional code slew limiter: define PID_DAC_SLEW_LIMIT_EN.
module pid_dac_spi #(
    parameter int In_width   = 32,
    parameter int Width      = 16,
    parameter int Clk_div    = 4,
    parameter int Offset_bin = 1
) (
    input  logic             i_clkp,
    input  logic             i_rstn,
    pid_dac_spi_if.slave     bus,
    input  logic [Width-1:0] i_max_step,
    output logic [Width-1:0] o_code,
    output logic             o_busy
);
    localparam int DivW = (Clk_div > 1) ? $clog2(Clk_div) : 1;
    localparam int BitW = $clog2(Width);
    localparam logic [DivW-1:0]     DivLast = DivW'(Clk_div - 1);
    localparam logic [Width-1:0]    MsbMask = {1'b1, {(Width-1){1'b0}}};
    localparam logic [In_width-1:0] SatMax  = {{(In_width-Width+1){1'b0}}, {(Width-1){1'b1}}};
    localparam logic [In_width-1:0] SatMin  = {{(In_width-Width+1){1'b1}}, {(Width-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, LOAD} state_t;

    state_t            state_q, state_n;
    logic [DivW-1:0]   div_q, div_n;
    logic [BitW-1:0]   bit_q, bit_n;
    logic [Width-1:0]  pend_q, pend_n, code_n;
    logic              sclk_n, sdi_n, csn_n, ldacn_n, ready_n;
    logic [Width-1:0]  sat, raw_code, new_code;

    // Full-width signed compare before truncation to the DAC range.
    always_comb begin
        if ($signed(bus.data) > $signed(SatMax)) begin
            sat = SatMax[Width-1:0];
        end else if ($signed(bus.data) < $signed(SatMin)) begin
            sat = SatMin[Width-1:0];
        end else begin
            sat = bus.data[Width-1:0];
        end
        raw_code = (Offset_bin != 0) ? (sat ^ MsbMask) : sat;
    end

`ifdef PID_DAC_SLEW_LIMIT_EN
    // Limit in offset-binary order so one unsigned compare serves both code formats.
    localparam logic [Width-1:0] Flip = (Offset_bin != 0) ? '0 : MsbMask;
    logic [Width:0]   cur, tgt, hi, lo, step;
    logic [Width-1:0] lim;

    always_comb begin
        step = {1'b0, i_max_step};
        cur  = {1'b0, o_code ^ Flip};
        tgt  = {1'b0, raw_code ^ Flip};
        hi   = cur + step;
        if (hi[Width]) hi = {1'b0, {Width{1'b1}}};
        lo   = (cur > step) ? (cur - step) : '0;
        if (i_max_step == '0)  lim = tgt[Width-1:0];
        else if (tgt > hi)     lim = hi[Width-1:0];
        else if (tgt < lo)     lim = lo[Width-1:0];
        else                   lim = tgt[Width-1:0];
        new_code = lim ^ Flip;
    end
`else
    logic unused_max_step;
    assign unused_max_step = ^i_max_step;
    assign new_code        = raw_code;
`endif

    always_comb begin
        state_n = state_q;
        div_n   = div_q;
        bit_n   = bit_q;
        pend_n  = pend_q;
        code_n  = o_code;
        sclk_n  = bus.sclk;
        sdi_n   = bus.sdi;
        csn_n   = bus.csn;
        ldacn_n = bus.ldacn;
        ready_n = bus.ready;
        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    state_n = SHIFT;
                    div_n   = '0;
                    bit_n   = BitW'(Width - 1);
                    pend_n  = new_code;
                    sdi_n   = new_code[Width-1];
                    sclk_n  = 1'b0;
                    csn_n   = 1'b0;
                    ready_n = 1'b0;
                end
            end
            SHIFT: begin
                if (div_q == DivLast) begin
                    div_n = '0;
                    if (!bus.sclk) begin
                        sclk_n = 1'b1;
                    end else if (bit_q == '0) begin
                        state_n = HOLD;
                        sclk_n  = 1'b0;
                        sdi_n   = 1'b0;
                        csn_n   = 1'b1;
                    end else begin
                        bit_n  = bit_q - 1'b1;
                        sclk_n = 1'b0;
                        sdi_n  = pend_q[bit_n];
                    end
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_q == DivLast) begin
                    div_n   = '0;
                    state_n = LOAD;
                    ldacn_n = 1'b0;
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            LOAD: begin
                if (div_q == DivLast) begin
                    div_n   = '0;
                    state_n = IDLE;
                    ldacn_n = 1'b1;
                    ready_n = 1'b1;
                    code_n  = pend_q;
                end else begin
                    div_n = div_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            pend_q    <= '0;
            o_code    <= '0;
            o_busy    <= 1'b0;
            bus.sclk  <= 1'b0;
            bus.sdi   <= 1'b0;
            bus.csn   <= 1'b1;
            bus.ldacn <= 1'b1;
            bus.ready <= 1'b1;
        end else begin
            state_q   <= state_n;
            div_q     <= div_n;
            bit_q     <= bit_n;
            pend_q    <= pend_n;
            o_code    <= code_n;
            o_busy    <= ~ready_n;
            bus.sclk  <= sclk_n;
            bus.sdi   <= sdi_n;
            bus.csn   <= csn_n;
            bus.ldacn <= ldacn_n;
            bus.ready <= ready_n;
        end
    end
endmodule
